// File: rtl/seq_detector_param_if.sv
// Serial detector signal bundle: the serial data input plus the match, heartbeat,
// history and counter outputs, shared between the detector and its driver.
interface seq_detector_param_if #(
  parameter int PAT_LEN = 5,
  parameter int CNT_W   = 8
);
  logic               w;
  logic               z;
  logic               clk_tick;
  logic               W;
  logic [PAT_LEN-1:0] state;
  logic [CNT_W-1:0]   match_cnt;

  modport master (
    output w,
    input  z,
    input  clk_tick,
    input  W,
    input  state,
    input  match_cnt
  );

  modport slave (
    input  w,
    output z,
    output clk_tick,
    output W,
    output state,
    output match_cnt
  );
endinterface

// File: rtl/seq_detector_param.sv
// Parametrised serial pattern detector: samples w once per divided-clock tick,
// matches the last PAT_LEN samples against PATTERN and counts matches (saturating).
module seq_detector_param #(
  parameter int                 PAT_LEN = 5,
  parameter logic [PAT_LEN-1:0] PATTERN = 5'b10010,
  parameter bit                 OVERLAP = 1'b1,
  parameter bit                 MOORE   = 1'b0,
  parameter int                 DIV     = 400_000_000,
  parameter int                 CNT_W   = 8
) (
  input logic            clk,
  input logic            reset,
  seq_detector_param_if.slave bus
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int FW = $clog2(PAT_LEN + 1);

  localparam logic [DW-1:0]    DIV_LAST  = DW'(DIV - 1);
  localparam logic [FW-1:0]    FILL_FULL = FW'(PAT_LEN);
  localparam logic [FW-1:0]    FILL_MIN  = FW'(PAT_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  logic [DW-1:0]      r_div_cnt;
  logic [FW-1:0]      r_fill;
  logic [PAT_LEN-1:0] r_state;
  logic               r_w_q;
  logic               r_clk_tick;
  logic [CNT_W-1:0]   r_match_cnt;

  logic               w_tick;
  logic [PAT_LEN-1:0] w_hist_next;
  logic               w_match;
  logic [FW-1:0]      w_fill_next;
  logic [CNT_W-1:0]   w_cnt_next;

  assign w_tick = (r_div_cnt == DIV_LAST);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_div_cnt <= '0;
    end else if (w_tick) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

  // The match looks at the history as it will be after this tick's shift,
  // so the final pattern bit comes straight from the live input.
  assign w_hist_next = {r_state[PAT_LEN-2:0], bus.w};
  assign w_match     = (r_fill >= FILL_MIN) && (w_hist_next == PATTERN);

  always_comb begin
    w_fill_next = r_fill;
    if (r_fill != FILL_FULL) begin
      w_fill_next = r_fill + 1'b1;
    end
    if (w_match && !OVERLAP) begin
      w_fill_next = '0;
    end
  end

  always_comb begin
    w_cnt_next = r_match_cnt;
    if (w_match && (r_match_cnt != CNT_MAX)) begin
      w_cnt_next = r_match_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_fill      <= '0;
      r_state     <= '0;
      r_w_q       <= 1'b0;
      r_clk_tick  <= 1'b0;
      r_match_cnt <= '0;
    end else if (w_tick) begin
      r_fill      <= w_fill_next;
      r_state     <= w_hist_next;
      r_w_q       <= bus.w;
      r_clk_tick  <= ~r_clk_tick;
      r_match_cnt <= w_cnt_next;
    end
  end

  generate
    if (MOORE) begin : g_moore
      logic r_z;

      always_ff @(posedge clk) begin
        if (!reset) begin
          r_z <= 1'b0;
        end else if (w_tick) begin
          r_z <= w_match;
        end
      end

      assign bus.z = r_z;
    end else begin : g_mealy
      assign bus.z = w_match;
    end
  endgenerate

  assign bus.clk_tick  = r_clk_tick;
  assign bus.W         = r_w_q;
  assign bus.state     = r_state;
  assign bus.match_cnt = r_match_cnt;

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: three configurations driven together and compared
// every clock against a sample-history reference model.
module tb_seq_detector_param;

  localparam int PL [3] = '{5, 4, 3};
  localparam int PT [3] = '{5'b10010, 4'b1011, 3'b111};
  localparam int DV [3] = '{4, 3, 1};
  localparam bit OV [3] = '{1'b1, 1'b0, 1'b1};
  localparam bit MO [3] = '{1'b0, 1'b1, 1'b0};
  localparam int CW [3] = '{8, 2, 2};

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  int errors = 0;
  int checks = 0;

  // Reference model: per-instance tick phase, valid-sample count, last samples,
  // last sampled bit, heartbeat, match count and registered match.
  int divm  [3];
  int fillm [3];
  int stm   [3];
  int cntm  [3];
  bit wm    [3];
  bit ctm   [3];
  bit mzm   [3];
  bit win   [3];

  seq_detector_param_if #(.PAT_LEN(5), .CNT_W(8)) ifa ();
  seq_detector_param_if #(.PAT_LEN(4), .CNT_W(2)) ifb ();
  seq_detector_param_if #(.PAT_LEN(3), .CNT_W(2)) ifc ();

  seq_detector_param #(
    .PAT_LEN(5), .PATTERN(5'b10010), .OVERLAP(1'b1), .MOORE(1'b0), .DIV(4), .CNT_W(8)
  ) dut_a (.clk(clk), .reset(rst_n), .bus(ifa.slave));

  seq_detector_param #(
    .PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .MOORE(1'b1), .DIV(3), .CNT_W(2)
  ) dut_b (.clk(clk), .reset(rst_n), .bus(ifb.slave));

  seq_detector_param #(
    .PAT_LEN(3), .PATTERN(3'b111), .OVERLAP(1'b1), .MOORE(1'b0), .DIV(1), .CNT_W(2)
  ) dut_c (.clk(clk), .reset(rst_n), .bus(ifc.slave));

  always #5 clk = ~clk;

  function automatic bit model_m(int i, bit wv);
    int last = ((stm[i] << 1) | int'(wv)) & ((1 << PL[i]) - 1);
    return (fillm[i] >= PL[i] - 1) && (last == PT[i]);
  endfunction

  function automatic bit exp_z(int i);
    return MO[i] ? mzm[i] : model_m(i, win[i]);
  endfunction

  task automatic model_edge();
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        divm[i] = 0; fillm[i] = 0; stm[i] = 0; cntm[i] = 0;
        wm[i] = 1'b0; ctm[i] = 1'b0; mzm[i] = 1'b0;
      end else if (divm[i] == DV[i] - 1) begin
        bit hit = model_m(i, win[i]);
        divm[i]  = 0;
        stm[i]   = ((stm[i] << 1) | int'(win[i])) & ((1 << PL[i]) - 1);
        wm[i]    = win[i];
        ctm[i]   = ~ctm[i];
        fillm[i] = (fillm[i] + 1 > PL[i]) ? PL[i] : fillm[i] + 1;
        if (hit && !OV[i]) fillm[i] = 0;
        if (hit && cntm[i] < (1 << CW[i]) - 1) cntm[i] = cntm[i] + 1;
        if (MO[i]) mzm[i] = hit;
      end else begin
        divm[i] = divm[i] + 1;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("A.z",         ifa.z,         exp_z(0));
    chk("A.clk_tick",  ifa.clk_tick,  ctm[0]);
    chk("A.W",         ifa.W,         wm[0]);
    chk("A.state",     ifa.state,     stm[0]);
    chk("A.match_cnt", ifa.match_cnt, cntm[0]);
    chk("B.z",         ifb.z,         exp_z(1));
    chk("B.clk_tick",  ifb.clk_tick,  ctm[1]);
    chk("B.W",         ifb.W,         wm[1]);
    chk("B.state",     ifb.state,     stm[1]);
    chk("B.match_cnt", ifb.match_cnt, cntm[1]);
    chk("C.z",         ifc.z,         exp_z(2));
    chk("C.clk_tick",  ifc.clk_tick,  ctm[2]);
    chk("C.W",         ifc.W,         wm[2]);
    chk("C.state",     ifc.state,     stm[2]);
    chk("C.match_cnt", ifc.match_cnt, cntm[2]);
  endtask

  // Drive one clock's inputs at the negedge, compare just after, then advance.
  task automatic step(input bit rn, input bit a, input bit b, input bit c);
    rst_n = rn;
    ifa.w = a; ifb.w = b; ifc.w = c;
    win[0] = a; win[1] = b; win[2] = c;
    #1;
    check_all();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic feed_a(input bit b);
    for (int k = 0; k < 4; k++) begin
      step(1'b1, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    bit ovl_seq [8] = '{1, 0, 0, 1, 0, 0, 1, 0};
    bit pre_seq [4] = '{1, 0, 0, 1};
    bit post_seq [6] = '{0, 1, 0, 0, 1, 0};
    int sat_exp [10] = '{0, 0, 1, 2, 3, 3, 3, 3, 3, 3};

    rst_n = 1'b0;
    ifa.w = 1'b0; ifb.w = 1'b0; ifc.w = 1'b0;
    win[0] = 1'b0; win[1] = 1'b0; win[2] = 1'b0;
    @(posedge clk);
    model_edge();
    @(negedge clk);

    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst.A.state",     ifa.state,     0);
    chk("rst.A.match_cnt", ifa.match_cnt, 0);
    chk("rst.A.clk_tick",  ifa.clk_tick,  0);
    chk("rst.B.z",         ifb.z,         0);

    // Overlapping detection: 10010010 yields matches on ticks 5 and 8.
    foreach (ovl_seq[k]) feed_a(ovl_seq[k]);
    chk("ovl.A.match_cnt", ifa.match_cnt, 2);

    // Saturation on the 3-bit, DIV=1 instance.
    step(1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
      chk($sformatf("sat.C.cnt%0d", k), ifc.match_cnt, sat_exp[k]);
    end

    // Reset in the middle of a partial pattern discards the history.
    step(1'b0, 1'b0, 1'b0, 1'b0);
    foreach (pre_seq[k]) feed_a(pre_seq[k]);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("midrst.A.state",     ifa.state,     0);
    chk("midrst.A.W",         ifa.W,         0);
    chk("midrst.A.match_cnt", ifa.match_cnt, 0);
    foreach (post_seq[k]) feed_a(post_seq[k]);
    chk("midrst.A.match_cnt1", ifa.match_cnt, 1);

    // Random traffic with occasional resets.
    for (int k = 0; k < 4000; k++) begin
      step(1'($urandom_range(0, 299) != 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
